// File: rtl/seven_segment.sv
// seven_segment
//   Time-multiplexed driver for a NUM_SEGMENTS-digit common-anode 7-segment
//   display. One hex nibble and one active-low decimal point per digit are
//   scanned round-robin, each digit held for INTERVAL clocks.
//
//   Ports
//     clk          single clock, all state on posedge
//     reset        asynchronous, active-low
//     encoded      [NUM_SEGMENTS-1:0][3:0] hex nibble per digit
//     digit_point  [NUM_SEGMENTS-1:0] DP per digit, active-low
//     anode        [NUM_SEGMENTS-1:0] digit enables, active-low one-hot
//     cathode      [7:0] {DP,G,F,E,D,C,B,A}, active-low

// Per-digit hex-to-segment decoder, active-low outputs, bit0 = A.
module seven_segment_hex (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h7F;
      unique case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end
endmodule

module seven_segment #(
   parameter int NUM_SEGMENTS = 8,
   parameter int CLK_PER      = 10,
   parameter int REFR_RATE    = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SEGMENTS-1:0][3:0] encoded,
   input  logic [NUM_SEGMENTS-1:0]      digit_point,
   output logic [NUM_SEGMENTS-1:0]      anode,
   output logic [7:0]                   cathode
);
   localparam int INTERVAL_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE);
   localparam int INTERVAL     = (INTERVAL_RAW < 1) ? 1 : INTERVAL_RAW;
   localparam int CNT_W        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam int IDX_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

   logic [CNT_W-1:0]                cnt;
   logic [IDX_W-1:0]                idx;
   logic [NUM_SEGMENTS-1:0][6:0]    seg_all;

   // One decoder per digit; the scan just selects the current one.
   genvar g;
   generate
      for (g = 0; g < NUM_SEGMENTS; g++) begin : g_dec
         seven_segment_hex u_hex (
            .nibble (encoded[g]),
            .seg    (seg_all[g])
         );
      end
   endgenerate

   wire cnt_wrap = (cnt == CNT_W'(INTERVAL - 1));
   wire idx_wrap = (idx == IDX_W'(NUM_SEGMENTS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         idx     <= '0;
         anode   <= '1;
         cathode <= 8'hFF;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + 1'b1;
         if (cnt_wrap)
            idx <= idx_wrap ? '0 : idx + 1'b1;
         // Anode and cathode come from the same idx on the same edge, so a
         // digit change never shows the old pattern on the new digit.
         anode   <= ~(NUM_SEGMENTS'(1) << idx);
         cathode <= {digit_point[idx], seg_all[idx]};
      end
   end
endmodule

// File: tb/tb_seven_segment.sv
module tb_seven_segment;
   localparam int N        = 8;
   localparam int INTERVAL = 10;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0][3:0] enc = '0;
   logic [N-1:0]   dp = '1;
   logic [N-1:0]   anode;
   logic [7:0]     cathode;

   int n_chk = 0;
   int n_err = 0;
   int k = 0;          // posedges since reset release

   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seven_segment #(.NUM_SEGMENTS(N), .CLK_PER(10), .REFR_RATE(10_000_000)) dut (
      .clk         (clk),
      .reset       (reset),
      .encoded     (enc),
      .digit_point (dp),
      .anode       (anode),
      .cathode     (cathode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   // Reference: after edge k the digit shown is ((k-1)/INTERVAL) mod N,
   // decoded from the inputs that were present at that edge.
   function automatic int cur_digit(input int kk);
      return ((kk - 1) / INTERVAL) % N;
   endfunction

   task automatic step;
      int d;
      logic [N-1:0] ean;
      @(posedge clk);
      k++;
      #1;
      d   = cur_digit(k);
      ean = ~(N'(1) << d);
      chk("anode", anode, ean);
      chk("cathode", cathode, {dp[d], hex_tbl[enc[d]]});
   endtask

   task automatic release_reset;
      @(negedge clk);
      reset = 1'b1;
      k = 0;
   endtask

   initial begin
      // 1. reset held with arbitrary inputs
      for (int i = 0; i < 4; i++) begin
         enc = $urandom;
         dp  = $urandom;
         @(posedge clk); #1;
         chk("rst_anode", anode, 8'hFF);
         chk("rst_cathode", cathode, 8'hFF);
      end
      enc = 32'h76543210;
      dp  = 8'hFF;
      release_reset();
      step();
      chk("first_anode", anode, 8'hFE);
      chk("first_cathode", cathode, 8'hC0);

      // 2/3. full scan twice: dwell and wrap
      for (int i = 1; i < 2 * N * INTERVAL; i++) step();
      step();
      chk("wrap_anode", anode, 8'hFE);

      // 4. alternate pattern and DP
      enc = 32'hFEDCBA98;
      dp  = 8'hAA;
      for (int i = 0; i < 2 * N * INTERVAL; i++) step();

      // 5. change digit 0 nibble while it is displayed
      for (int i = 0; i < 200; i++) begin
         if (cur_digit(k) == 0 && ((k - 1) % INTERVAL) == 1) break;
         step();
      end
      chk("d0_reached", cur_digit(k), 0);
      enc[0] = 4'h0;
      dp[0]  = 1'b1;
      step();
      chk("d0_c0", cathode, 8'hC0);
      enc[0] = 4'h8;
      step();
      chk("d0_80", cathode, 8'h80);
      for (int i = 0; i < INTERVAL; i++) step();
      chk("d0_dwell_end", anode, 8'hFD);

      // random inputs against the model
      for (int i = 0; i < 400; i++) begin
         step();
         if ($urandom_range(0, 3) == 0) enc[$urandom_range(0, N - 1)] = 4'($urandom);
         if ($urandom_range(0, 7) == 0) dp = 8'($urandom);
      end

      // 6. async reset mid-dwell on digit 5
      for (int i = 0; i < 200; i++) begin
         if (cur_digit(k) == 5 && ((k - 1) % INTERVAL) == 4) break;
         step();
      end
      chk("d5_reached", cur_digit(k), 5);
      chk("d5_anode", anode, 8'hDF);
      #2;
      reset = 1'b0;
      #1;
      chk("async_anode", anode, 8'hFF);
      chk("async_cathode", cathode, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("held_anode", anode, 8'hFF);
         chk("held_cathode", cathode, 8'hFF);
      end
      enc = 32'h13579BDF;
      dp  = 8'h5A;
      release_reset();
      for (int i = 0; i < INTERVAL; i++) begin
         step();
         chk("post_rst_d0", anode, 8'hFE);
      end
      step();
      chk("post_rst_d1", anode, 8'hFD);
      for (int i = 0; i < 100; i++) begin
         step();
         if ($urandom_range(0, 2) == 0) enc[$urandom_range(0, N - 1)] = 4'($urandom);
         if ($urandom_range(0, 4) == 0) dp = 8'($urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
